// File: rtl/fir_pkg.sv
// Shared FIR constants and the signed sample/accumulator types used by the
// core and by the output quantiser.
package fir_pkg;

  localparam int FIR_ACC_W       = 41;
  localparam int FIR_DATA_W      = 16;
  localparam int FIR_TAPS        = 64;
  localparam int FIR_COEF_ADDR_W = 6;

  typedef logic signed [FIR_DATA_W-1:0] fir_data_t;
  typedef logic signed [FIR_ACC_W-1:0]  fir_acc_t;

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous show-ahead FIFO. Pointers carry one extra wrap bit, so full is
// "pointers equal except the MSB". A push while full is accepted only when a
// pop happens on the same edge. The head word reads as zero while empty.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter  int W     = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  // Pointer next-state: advance on accepted push / effective pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/fir_out_quant.sv
// FIR output quantiser: register the accumulator result, round with a fixed
// arithmetic right shift (half toward +inf), saturate to OUT_W bits and queue
// in a show-ahead FIFO. Optional clipped-sample counter: FIR_OUT_SAT_COUNT_EN.
//
// Handshake: dout_valid is high whenever the FIFO holds a word and dout shows
// the head word; a word is consumed on a rising clk1 edge where
// dout_valid && dout_ready. dout holds steady while dout_valid && !dout_ready.
// The input side has no back-pressure: din_valid is a strobe, and a word that
// reaches a full FIFO without a same-edge pop is dropped (sticky overflow).
module fir_out_quant
  import fir_pkg::*;
#(
  parameter  int IN_W       = FIR_ACC_W,
  parameter  int OUT_W      = FIR_DATA_W,
  parameter  int SHIFT      = 15,
  parameter  int FIFO_DEPTH = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk1,
  input  logic                    rstn,
  input  logic                    din_valid,
  input  logic signed [IN_W-1:0]  din,
  input  logic                    sat_clr,
  input  logic                    dout_ready,
  output logic                    dout_valid,
  output logic signed [OUT_W-1:0] dout,
  output logic [LVL_W-1:0]        fifo_level,
  output logic                    overflow,
  output logic                    sat_flag
`ifdef FIR_OUT_SAT_COUNT_EN
  ,
  output logic [15:0]             sat_count
`endif
);

  // One guard bit so the rounding add can never wrap.
  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0]    MAX_R = RW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0]    MIN_R = RW'(-(2 ** (OUT_W - 1)));
  localparam logic signed [OUT_W-1:0] MAX_O = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_O = {1'b1, {(OUT_W - 1){1'b0}}};

  logic                    in_vld_q;
  logic signed [IN_W-1:0]  in_q;
  logic                    rnd_vld_q;
  logic signed [RW-1:0]    rnd_q;
  logic signed [RW-1:0]    din_ext;
  logic signed [RW-1:0]    rnd_d;
  logic                    clip_d;
  logic                    clip_evt;
  logic signed [OUT_W-1:0] sat_val;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;
  logic                    drop_evt;
  logic                    sat_flag_q, sat_flag_d;
  logic                    ovf_q, ovf_d;
  logic [OUT_W-1:0]        fifo_rdata;

  assign din_ext = {in_q[IN_W-1], in_q};

  if (SHIFT > 0) begin : g_round
    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
    assign rnd_d = (din_ext + HALF) >>> SHIFT;
  end else begin : g_pass
    assign rnd_d = din_ext;
  end

  assign clip_d   = (rnd_d > MAX_R) || (rnd_d < MIN_R);
  assign clip_evt = in_vld_q && clip_d;
  assign pop      = dout_valid && dout_ready;
  assign drop_evt = rnd_vld_q && fifo_full && !pop;

  // Capture stage (E0) and rounded stage (E1) registers.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      in_vld_q  <= 1'b0;
      in_q      <= '0;
      rnd_vld_q <= 1'b0;
      rnd_q     <= '0;
    end else begin
      in_vld_q  <= din_valid;
      in_q      <= din;
      rnd_vld_q <= in_vld_q;
      rnd_q     <= rnd_d;
    end
  end

  // Saturate the registered rounded value on its way into the FIFO (E2).
  always_comb begin
    sat_val = rnd_q[OUT_W-1:0];
    if (rnd_q > MAX_R)      sat_val = MAX_O;
    else if (rnd_q < MIN_R) sat_val = MIN_O;
  end

  // Sticky flags: clear first, so a same-edge set wins.
  always_comb begin
    sat_flag_d = sat_flag_q;
    ovf_d      = ovf_q;
    if (sat_clr) begin
      sat_flag_d = 1'b0;
      ovf_d      = 1'b0;
    end
    if (clip_evt) sat_flag_d = 1'b1;
    if (drop_evt) ovf_d      = 1'b1;
  end

  // Flag registers.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      sat_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
      ovf_q      <= ovf_d;
    end
  end

  assign sat_flag = sat_flag_q;
  assign overflow = ovf_q;

`ifdef FIR_OUT_SAT_COUNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Clip counter: saturates at all-ones; a clip on the clearing edge counts 1.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) sat_cnt_d = '0;
    if (clip_evt && (sat_cnt_d != 16'hFFFF)) sat_cnt_d = sat_cnt_d + 16'd1;
  end

  // Clip counter register.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) sat_cnt_q <= '0;
    else       sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`endif

  fir_out_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk1),
    .rst_n_i (rstn),
    .push_i  (rnd_vld_q),
    .pop_i   (dout_ready),
    .wdata_i (sat_val),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign dout_valid = !fifo_empty;
  assign dout       = fifo_rdata;

endmodule
